bin2gray_ptr: RTL and testbench

- Sequential binary-to-Gray encoder; the encoding counterpart of the team's combinational Gray-to-binary decoder.
- Two independent functions share one clock:
  - a Gray-coded pointer counter (registered binary count plus registered Gray image);
  - a valid/ready streaming encoder channel with a 2-entry skid buffer.
- Used by bcp_unit producers that publish counts or pointers in Gray form for later decoding by the conflict analyzer path.

---
 rtl/bin2gray_ptr_if.sv | 37 +++
 rtl/bin2gray_ptr.sv | 129 ++++++++++++
 tb/tb_bin2gray_ptr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2gray_ptr_if.sv
// Stream channel bundle for bin2gray_ptr: binary words in, Gray words out,
// plus a debug view of the skid-buffer occupancy state.
interface bin2gray_ptr_if #(
    parameter int SIZE = 8
);
    // Valid/ready semantics on both sides: a word moves on a rising edge
    // exactly when valid && ready are both high in the cycle before that edge.
    // A producer holding valid=1 keeps its data stable until the word moves;
    // valid never waits on ready. in_ready is a registered output.
    logic            in_valid;
    logic [SIZE-1:0] in_bin;
    logic            in_ready;
    logic            out_valid;
    logic [SIZE-1:0] out_gray;
    logic            out_ready;
    logic [1:0]      dbg_state;

    modport master (
        output in_valid,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_gray,
        input  dbg_state
    );

    modport slave (
        input  in_valid,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_gray,
        output dbg_state
    );
endinterface

// File: rtl/bin2gray_ptr.sv
// Binary-to-Gray encoder: a Gray-coded pointer counter and an independent
// valid/ready encoder channel with an output register plus one skid entry.
module bin2gray_ptr #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cnt_load,
    input  logic [SIZE-1:0] cnt_load_bin,
    input  logic            cnt_inc,
    output logic [SIZE-1:0] cnt_bin,
    output logic [SIZE-1:0] cnt_gray,
    output logic            cnt_wrap,
    bin2gray_ptr_if.slave   strm
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic [SIZE-1:0] enc(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- pointer counter ----------------
    logic [SIZE-1:0] cnt_bin_q;
    logic [SIZE-1:0] cnt_gray_q;
    logic            cnt_wrap_q;
    logic [SIZE-1:0] cnt_bin_inc;

    assign cnt_bin_inc = cnt_bin_q + SIZE'(1);

    // The Gray image is registered from the next binary value so that the
    // published pointer never glitches through combinational decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_bin_q  <= '0;
            cnt_gray_q <= '0;
            cnt_wrap_q <= 1'b0;
        end else if (cnt_load) begin
            cnt_bin_q  <= cnt_load_bin;
            cnt_gray_q <= enc(cnt_load_bin);
            cnt_wrap_q <= 1'b0;
        end else if (cnt_inc) begin
            cnt_bin_q  <= cnt_bin_inc;
            cnt_gray_q <= enc(cnt_bin_inc);
            cnt_wrap_q <= &cnt_bin_q;
        end else begin
            cnt_wrap_q <= 1'b0;
        end
    end

    assign cnt_bin  = cnt_bin_q;
    assign cnt_gray = cnt_gray_q;
    assign cnt_wrap = cnt_wrap_q;

    // ---------------- stream encoder ----------------
    state_t          state_q;
    logic            out_valid_q;
    logic [SIZE-1:0] out_gray_q;
    logic [SIZE-1:0] skid_gray_q;
    logic            in_ready_q;
    logic            accept;
    logic            xfer;

    assign accept = strm.in_valid && in_ready_q;
    assign xfer   = out_valid_q && strm.out_ready;

    // Words are encoded on entry, so the skid entry already holds Gray data
    // and can move straight into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_gray_q  <= '0;
            skid_gray_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_gray_q  <= enc(strm.in_bin);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, xfer})
                        2'b11: begin
                            out_gray_q <= enc(strm.in_bin);
                        end
                        2'b10: begin
                            skid_gray_q <= enc(strm.in_bin);
                            in_ready_q  <= 1'b0;
                            state_q     <= ST_TWO;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_EMPTY;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (xfer) begin
                        out_gray_q <= skid_gray_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_gray  = out_gray_q;
    assign strm.dbg_state = state_q;

endmodule

// File: tb/tb_bin2gray_ptr.sv
// Directed bench for bin2gray_ptr: SIZE=4 instance for the counter sequence,
// SIZE=8 instance for the stream channel, counter load and reset checks.
module tb_bin2gray_ptr;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;
    int n_acc;
    int n_xfer;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT instances ----------------
    logic       c4_load;
    logic [3:0] c4_ld_bin;
    logic       c4_inc;
    logic [3:0] c4_bin;
    logic [3:0] c4_gray;
    logic       c4_wrap;

    logic       c8_load;
    logic [7:0] c8_ld_bin;
    logic       c8_inc;
    logic [7:0] c8_bin;
    logic [7:0] c8_gray;
    logic       c8_wrap;

    bin2gray_ptr_if #(.SIZE(4)) bus4 ();
    bin2gray_ptr_if #(.SIZE(8)) bus8 ();

    bin2gray_ptr #(.SIZE(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .cnt_load     (c4_load),
        .cnt_load_bin (c4_ld_bin),
        .cnt_inc      (c4_inc),
        .cnt_bin      (c4_bin),
        .cnt_gray     (c4_gray),
        .cnt_wrap     (c4_wrap),
        .strm         (bus4)
    );

    bin2gray_ptr #(.SIZE(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .cnt_load     (c8_load),
        .cnt_load_bin (c8_ld_bin),
        .cnt_inc      (c8_inc),
        .cnt_bin      (c8_bin),
        .cnt_gray     (c8_gray),
        .cnt_wrap     (c8_wrap),
        .strm         (bus8)
    );

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stream(input logic v, input logic [7:0] b, input logic r);
        bus8.in_valid  = v;
        bus8.in_bin    = b;
        bus8.out_ready = r;
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       hold_prev;
    logic [7:0] prev_gray;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(bus8.out_valid), 32'd1);
                chk("hold_gray", 32'(bus8.out_gray), 32'(prev_gray));
            end
            if (bus8.out_valid && bus8.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0)
                    chk("sb_extra_word", 32'(exp_q.size()), 32'd1);
                else
                    chk("sb_data", 32'(bus8.out_gray), 32'(exp_q.pop_front()));
            end
            if (bus8.in_valid && bus8.in_ready) begin
                n_acc++;
                exp_q.push_back(gray8(bus8.in_bin));
            end
            hold_prev = bus8.out_valid && !bus8.out_ready;
            prev_gray = bus8.out_gray;
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] gray_tab [0:16];
    logic [3:0] prev4;
    int         base_acc;
    int         base_xfer;

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        n_cmp = 0; n_err = 0; n_acc = 0; n_xfer = 0;
        hold_prev = 1'b0; prev_gray = '0;
        rst = 1'b1;
        c4_load = 1'b0; c4_ld_bin = '0; c4_inc = 1'b0;
        c8_load = 1'b0; c8_ld_bin = '0; c8_inc = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_bin = '0; bus4.out_ready = 1'b1;
        drive_stream(1'b0, 8'h00, 1'b1);
        step();
        step();

        // reset state
        chk("rst_cnt_bin", 32'(c4_bin), 32'h0);
        chk("rst_cnt_gray", 32'(c4_gray), 32'h0);
        chk("rst_cnt_wrap", 32'(c4_wrap), 32'h0);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'h0);
        chk("rst_out_gray", 32'(bus8.out_gray), 32'h0);
        chk("rst_in_ready", 32'(bus8.in_ready), 32'h1);
        rst = 1'b0;
        step();

        // 16 increments through the full SIZE=4 Gray sequence
        c4_inc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prev4 = c4_gray;
            step();
            chk("cnt_gray_seq", 32'(c4_gray), 32'(gray_tab[i+1]));
            chk("cnt_bin_seq", 32'(c4_bin), 32'((i + 1) % 16));
            chk("cnt_wrap_seq", 32'(c4_wrap), (i == 15) ? 32'd1 : 32'd0);
            chk("cnt_one_bit", 32'($countones(prev4 ^ c4_gray)), 32'd1);
        end
        c4_inc = 1'b0;
        step();
        chk("idle_wrap_clear", 32'(c4_wrap), 32'h0);
        chk("idle_bin_hold", 32'(c4_bin), 32'h0);

        // load wins over inc
        c4_load = 1'b1; c4_inc = 1'b1; c4_ld_bin = 4'hA;
        step();
        chk("load_bin", 32'(c4_bin), 32'hA);
        chk("load_gray", 32'(c4_gray), 32'hF);
        chk("load_wrap", 32'(c4_wrap), 32'h0);
        c4_inc = 1'b0; c4_ld_bin = 4'hF;
        step();
        chk("load_f_gray", 32'(c4_gray), 32'h8);
        c4_load = 1'b0; c4_inc = 1'b1;
        step();
        chk("wrap_bin", 32'(c4_bin), 32'h0);
        chk("wrap_gray", 32'(c4_gray), 32'h0);
        chk("wrap_pulse", 32'(c4_wrap), 32'h1);
        c4_inc = 1'b0;
        step();
        chk("wrap_pulse_end", 32'(c4_wrap), 32'h0);

        // 256 words back to back
        base_xfer = n_xfer;
        for (int n = 0; n < 256; n++) begin
            drive_stream(1'b1, 8'(n), 1'b1);
            chk("stream_in_ready", 32'(bus8.in_ready), 32'h1);
            step();
            if (n == 8'h80) chk("enc_80", 32'(bus8.out_gray), 32'hC0);
            if (n == 8'hFF) chk("enc_ff", 32'(bus8.out_gray), 32'h80);
        end
        drive_stream(1'b0, 8'h00, 1'b1);
        step();
        chk("stream_count", 32'(n_xfer - base_xfer), 32'd256);
        chk("stream_idle", 32'(bus8.out_valid), 32'h0);

        // backpressure: exactly two words fit
        base_acc = n_acc;
        drive_stream(1'b1, 8'h11, 1'b0);
        step();
        chk("bp_valid", 32'(bus8.out_valid), 32'h1);
        chk("bp_gray1", 32'(bus8.out_gray), 32'h19);
        chk("bp_ready1", 32'(bus8.in_ready), 32'h1);
        drive_stream(1'b1, 8'h22, 1'b0);
        step();
        chk("bp_ready_full", 32'(bus8.in_ready), 32'h0);
        chk("bp_state_full", 32'(bus8.dbg_state), 32'h2);
        drive_stream(1'b1, 8'h33, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_ready", 32'(bus8.in_ready), 32'h0);
            chk("bp_stall_gray", 32'(bus8.out_gray), 32'h19);
        end
        chk("bp_accepts", 32'(n_acc - base_acc), 32'd2);
        drive_stream(1'b0, 8'h00, 1'b1);
        step();
        chk("bp_skid_gray", 32'(bus8.out_gray), 32'h33);
        chk("bp_skid_valid", 32'(bus8.out_valid), 32'h1);
        chk("bp_ready_back", 32'(bus8.in_ready), 32'h1);
        step();
        chk("bp_drained", 32'(bus8.out_valid), 32'h0);

        // random handshakes
        base_acc = n_acc;
        base_xfer = n_xfer;
        for (int k = 0; k < 10000; k++) begin
            drive_stream(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                         1'($urandom_range(0, 1)));
            step();
        end
        drive_stream(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() != 0) step();
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_no_loss", 32'(n_xfer - base_xfer), 32'(n_acc - base_acc));

        // reset with both entries full and counter at 5
        c8_load = 1'b1; c8_ld_bin = 8'h05;
        step();
        c8_load = 1'b0;
        chk("c8_load_bin", 32'(c8_bin), 32'h05);
        chk("c8_load_gray", 32'(c8_gray), 32'h07);
        drive_stream(1'b1, 8'h40, 1'b0);
        step();
        drive_stream(1'b1, 8'h41, 1'b0);
        step();
        chk("pre_rst_full", 32'(bus8.in_ready), 32'h0);
        drive_stream(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus8.out_valid), 32'h0);
        chk("arst_in_ready", 32'(bus8.in_ready), 32'h1);
        chk("arst_cnt_bin", 32'(c8_bin), 32'h0);
        chk("arst_cnt_gray", 32'(c8_gray), 32'h0);
        chk("arst_out_gray", 32'(bus8.out_gray), 32'h0);
        step();
        rst = 1'b0;
        drive_stream(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_no_stale", 32'(bus8.out_valid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
